gol_host_link: RTL and testbench
================================

# gol_host_link

Host-side driver for the tiny Game of Life engine's two-wire serial interface. It serializes an N-cell seed pattern onto the engine's data/start inputs, fires the start strobe, then watches the engine's 2-bit status and serial cell output and reassembles each emitted generation into a parallel frame. It sits between a parallel command source (test harness or host logic) and the engine, on the same clock.

## Interface
- N, 36: cells per board; all pattern and frame widths.
- GW, 8: width of generation count and frame counter.

- clock  in  1  rising-edge clock, shared with the engine.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_pattern  in  N  seed board; bit i = cell i.
- cmd_gens  in  GW  generations to capture; 0 = load and start only.
- gol_in  out  2  to engine: [0] serial data, [1] start strobe.
- gol_out  in  3  from engine: [2:1] status (00 INPUT, 01 UPDATE, 10 OUTPUT), [0] serial cell bit.
- frame_valid  out  1  one-cycle pulse, frame_data/frame_idx valid.
- frame_data  out  N  captured generation; bit k = k-th sample of the frame.
- frame_idx  out  GW  1-based generation number of frame_data.
- err_short  out  1  one-cycle pulse: frame ended with fewer than N samples.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the command completes.

## Operation
- gol_out registered once (st_q, bit_q) before any use; all decisions use registered copy.
- cmd_ready = (state == IDLE) && (st_q == 00). Engine only returns to INPUT via its own reset; block never resets it.
- States: IDLE, LOAD, START, WAIT, CAPTURE, DONE.
- IDLE: on handshake latch pattern and cmd_gens, clear counters -> LOAD.
- LOAD: N cycles, shift index i = 0..N-1; gol_in = {0, pattern[N-1-i]} (cell N-1 first, cell 0 last). After i = N-1 -> START.
- START: one cycle, gol_in = 2'b10 (data bit 0). If latched gens == 0 -> DONE, else -> WAIT.
- WAIT: gol_in = 00. On st_q == 10 -> CAPTURE, sample counter cleared, bit_q of that cycle taken as sample 0.
- CAPTURE: each cycle with st_q == 10 store bit_q into frame bit sample_cnt if sample_cnt < N; samples beyond N ignored; sample_cnt saturates at N.
- Frame end: st_q leaves 10. If sample_cnt >= N: pulse frame_valid, increment frame_idx, else pulse err_short (frame_idx unchanged, frame_data unchanged). Then if frame_idx == gens -> DONE, else -> WAIT.
- st_q == 00 while in WAIT/CAPTURE (engine reset externally): abort, pulse err_short, -> DONE.
- DONE: pulse done one cycle -> IDLE. Engine keeps running; later frames ignored.
- frame_idx width GW, wraps never: gens <= 2^GW-1 by construction.
- Reset: state IDLE, gol_in = 00, frame_valid/err_short/done = 0, busy = 0, frame_data = 0, frame_idx = 0, counters 0. Reset mid-command aborts immediately without done.

## Timing
- gol_in registered; handshake in cycle t drives first data bit at t+1; N data cycles t+1..t+N, start strobe at t+N+1.
- Engine status change visible in st_q one cycle after it appears on gol_out.
- frame_valid/err_short asserted the cycle after st_q first differs from 10 (registered pulse); frame_data/frame_idx update in that same cycle and hold until next frame.
- done asserted in the cycle DONE is occupied; cmd_ready may rise the next cycle.
- cmd_valid with cmd_ready low: ignored, no state change.

## Test plan
- Reset mid-LOAD at i=10 -> gol_in = 00, busy = 0, done never pulses, cmd_ready = 1 next cycle with st_q = 00.
- Pattern 36'h0_0000_0001, gens 0 -> gol_in[0] = 0 for 35 cycles then 1 at cycle 36, gol_in = 10 at cycle 37, done one cycle later, no frame_valid.
- Blinker (cells 7,8,9 of 6x6), gens 3 against engine model -> three frame_valid pulses, frame_idx 1,2,3, frames alternate vertical/horizontal blinker, done after third.
- Model emits 40 samples in OUTPUT -> frame_data holds first 36, frame_valid once; emits 20 samples -> err_short pulse, frame_idx unchanged, capture retried on next frame.
- cmd_valid high while engine status = 10 -> cmd_ready = 0, no LOAD entered; engine status forced 00 during WAIT -> err_short, done pulses.

Source files
------------

// File: rtl/gol_host_link.sv
// Host driver for the Game of Life engine: serializes a seed, fires start, then
// reassembles each OUTPUT burst into a parallel frame until the requested generation count.
module gol_host_link #(
  parameter int N  = 36,
  parameter int GW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_pattern,
  input  logic [GW-1:0] cmd_gens,
  output logic [1:0]    gol_in,
  input  logic [2:0]    gol_out,
  output logic          frame_valid,
  output logic [N-1:0]  frame_data,
  output logic [GW-1:0] frame_idx,
  output logic          err_short,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);
  localparam logic [1:0] ST_INPUT  = 2'b00;
  localparam logic [1:0] ST_OUTPUT = 2'b10;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CAPTURE, DONE} state_t;

  state_t        state, state_d;
  logic [1:0]    st_q;
  logic          bit_q;
  logic [N-1:0]  pattern_q, pattern_d;
  logic [N-1:0]  frame_buf, frame_buf_d;
  logic [N-1:0]  frame_data_d;
  logic [GW-1:0] gens_q, gens_d, frame_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          started_q, started_d;
  logic [1:0]    gol_in_d;
  logic          frame_valid_d, err_short_d, done_d;
  logic          handshake;

  assign cmd_ready = (state == IDLE) && (st_q == ST_INPUT);
  assign busy      = (state != IDLE);
  assign handshake = cmd_valid && cmd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      st_q        <= 2'b00;
      bit_q       <= 1'b0;
      pattern_q   <= '0;
      gens_q      <= '0;
      cnt_q       <= '0;
      started_q   <= 1'b0;
      frame_buf   <= '0;
      frame_data  <= '0;
      frame_idx   <= '0;
      gol_in      <= 2'b00;
      frame_valid <= 1'b0;
      err_short   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      st_q        <= gol_out[2:1];
      bit_q       <= gol_out[0];
      pattern_q   <= pattern_d;
      gens_q      <= gens_d;
      cnt_q       <= cnt_d;
      started_q   <= started_d;
      frame_buf   <= frame_buf_d;
      frame_data  <= frame_data_d;
      frame_idx   <= frame_idx_d;
      gol_in      <= gol_in_d;
      frame_valid <= frame_valid_d;
      err_short   <= err_short_d;
      done        <= done_d;
    end
  end

  // cnt_q is the shift index during LOAD and the sample count during WAIT/CAPTURE.
  // started_q masks the INPUT status the engine still shows right after the start strobe,
  // so only a return to INPUT after the engine has run counts as an abort.
  always_comb begin
    state_d       = state;
    pattern_d     = pattern_q;
    gens_d        = gens_q;
    cnt_d         = cnt_q;
    started_d     = started_q;
    frame_buf_d   = frame_buf;
    frame_data_d  = frame_data;
    frame_idx_d   = frame_idx;
    gol_in_d      = 2'b00;
    frame_valid_d = 1'b0;
    err_short_d   = 1'b0;
    done_d        = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          pattern_d   = cmd_pattern << 1;
          gens_d      = cmd_gens;
          cnt_d       = '0;
          started_d   = 1'b0;
          frame_idx_d = '0;
          gol_in_d    = {1'b0, cmd_pattern[N-1]};
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == LAST) begin
          gol_in_d = 2'b10;
          state_d  = START;
        end else begin
          gol_in_d  = {1'b0, pattern_q[N-1]};
          pattern_d = pattern_q << 1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      START: begin
        if (gens_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (st_q != ST_INPUT) started_d = 1'b1;
        if (st_q == ST_OUTPUT) begin
          frame_buf_d[0] = bit_q;
          cnt_d          = CW'(1);
          state_d        = CAPTURE;
        end else if (st_q == ST_INPUT && started_q) begin
          err_short_d = 1'b1;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      CAPTURE: begin
        if (st_q == ST_OUTPUT) begin
          if (cnt_q < FULL) begin
            frame_buf_d[cnt_q] = bit_q;
            cnt_d              = cnt_q + 1'b1;
          end
        end else if (st_q == ST_INPUT) begin
          err_short_d = 1'b1;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          if (cnt_q == FULL) begin
            frame_valid_d = 1'b1;
            frame_data_d  = frame_buf;
            frame_idx_d   = frame_idx + 1'b1;
          end else begin
            err_short_d = 1'b1;
          end
          if (frame_idx_d == gens_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gol_host_link.sv
// Bench for gol_host_link: behavioural engine (6x6 Life, no wrap) plus an event scoreboard.
module tb_gol_host_link;
  localparam int N = 36, GW = 8, SIDE = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [N-1:0]  cmd_pattern;
  logic [GW-1:0] cmd_gens;
  logic [1:0]    gol_in;
  logic [2:0]    gol_out;
  logic          frame_valid, err_short, busy, done;
  logic [N-1:0]  frame_data;
  logic [GW-1:0] frame_idx;

  gol_host_link #(.N(N), .GW(GW)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern), .cmd_gens(cmd_gens), .gol_in(gol_in), .gol_out(gol_out),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_idx(frame_idx),
    .err_short(err_short), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int kind; logic [N-1:0] data; int idx; int c; } ev_t;  // 1 frame, 2 short, 3 done
  typedef struct { int n; logic [N-1:0] data; int endc; } fr_t;
  ev_t dut_ev[$];
  fr_t eng_fr[$];
  int  samp_plan[$], next_plan[$];
  int  upd_len = 0;
  bit  eng_rst_req = 1'b0;
  logic [N-1:0] ref_fd = '0;

  function automatic ev_t mk_ev(input int kind, input logic [N-1:0] d, input int idx, input int c);
    ev_t e;
    e.kind = kind; e.data = d; e.idx = idx; e.c = c;
    return e;
  endfunction

  function automatic logic [N-1:0] life(input logic [N-1:0] b);
    logic [N-1:0] r;
    int nb;
    r = '0;
    for (int y = 0; y < SIDE; y++)
      for (int x = 0; x < SIDE; x++) begin
        nb = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < SIDE && x + dx >= 0 && x + dx < SIDE)
              nb += int'(b[(y + dy) * SIDE + x + dx]);
        r[y * SIDE + x] = (nb == 3) || (nb == 2 && b[y * SIDE + x]);
      end
    return r;
  endfunction

  function automatic int pick_upd();
    return (upd_len > 0) ? upd_len : int'($urandom_range(1, 4));
  endfunction

  // Engine: shifts gol_in[0] while in INPUT, steps on the start strobe, emits each generation.
  typedef enum {E_IN, E_UPD, E_OUT} e_t;
  e_t eng_st = E_IN;
  logic [N-1:0] shreg = '0, board = '0;
  int ucnt = 0, scnt = 0, ns = N;
  fr_t fr;
  initial begin
    gol_out = 3'b000;
    forever begin
      @(posedge clock); #1;
      if (eng_rst_req) begin
        eng_rst_req = 1'b0; eng_st = E_IN; shreg = '0; gol_out = 3'b000;
      end else begin
        case (eng_st)
          E_IN: if (gol_in == 2'b10) begin
            board = shreg; eng_st = E_UPD; ucnt = pick_upd(); gol_out = 3'b010;
          end else begin
            shreg = {shreg[N-2:0], gol_in[0]}; gol_out = 3'b000;
          end
          E_UPD: if (ucnt > 1) begin
            ucnt--; gol_out = 3'b010;
          end else begin
            board = life(board);
            ns = (samp_plan.size() > 0) ? samp_plan.pop_front() : N;
            gol_out = {2'b10, board[0]}; scnt = 1; eng_st = E_OUT;
          end
          default: if (scnt == ns) begin
            fr.n = ns; fr.data = board; fr.endc = cyc; eng_fr.push_back(fr);
            eng_st = E_UPD; ucnt = pick_upd(); gol_out = 3'b010;
          end else begin
            gol_out = {2'b10, (scnt < N) ? board[scnt] : 1'($urandom)}; scnt++;
          end
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (frame_valid) dut_ev.push_back(mk_ev(1, frame_data, int'(frame_idx), cyc));
      if (err_short)   dut_ev.push_back(mk_ev(2, frame_data, int'(frame_idx), cyc));
      if (done)        dut_ev.push_back(mk_ev(3, '0, 0, cyc));
    end
  end

  task automatic eng_reset();
    @(negedge clock); eng_rst_req = 1'b1;
    repeat (3) @(posedge clock);
    samp_plan = next_plan; next_plan.delete();
    dut_ev.delete(); eng_fr.delete();
  endtask

  task automatic do_handshake(input logic [N-1:0] pat, input int g, output int t);
    @(posedge clock); #1;
    cmd_pattern = pat; cmd_gens = GW'(g); cmd_valid = 1'b1; t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (cmd_ready) begin t = cyc; break; end
    end
    @(posedge clock); #1 cmd_valid = 1'b0;
    check("handshake", t >= 0, 1);
  endtask

  task automatic check_load(input logic [N-1:0] pat, input string tag);
    logic [N-1:0] obs;
    logic hi;
    hi = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clock); obs[N-1-i] = gol_in[0]; hi |= gol_in[1];
    end
    check({tag, "_load_bits"}, obs, pat);
    check({tag, "_load_strobe"}, hi, 0);
    @(negedge clock);
    check({tag, "_start"}, gol_in, 2'b10);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge clock); #1;
      foreach (dut_ev[j]) if (dut_ev[j].kind == 3) ok = 1;
    end
    check({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic compare_events(input int gens, input int done_c0, input string tag);
    ev_t exp[$];
    int idx, dc, m;
    idx = 0; dc = done_c0;
    foreach (eng_fr[j]) if (idx < gens) begin
      if (eng_fr[j].n >= N) begin
        idx++; ref_fd = eng_fr[j].data;
        exp.push_back(mk_ev(1, ref_fd, idx, eng_fr[j].endc + 2));
      end else begin
        exp.push_back(mk_ev(2, ref_fd, idx, eng_fr[j].endc + 2));
      end
      dc = eng_fr[j].endc + 2;
    end
    exp.push_back(mk_ev(3, '0, 0, dc));
    check({tag, "_nevents"}, dut_ev.size(), exp.size());
    m = (dut_ev.size() < exp.size()) ? dut_ev.size() : exp.size();
    for (int j = 0; j < m; j++) begin
      check({tag, "_kind"}, dut_ev[j].kind, exp[j].kind);
      check({tag, "_cycle"}, dut_ev[j].c, exp[j].c);
      if (exp[j].kind != 3) begin
        check({tag, "_data"}, dut_ev[j].data, exp[j].data);
        check({tag, "_idx"}, dut_ev[j].idx, exp[j].idx);
      end
    end
  endtask

  task automatic run_cmd(input logic [N-1:0] pat, input int gens, input string tag);
    int t;
    eng_reset();
    do_handshake(pat, gens, t);
    check_load(pat, tag);
    wait_done(tag);
    compare_events(gens, t + N + 2, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] hpat, vpat, p;
  logic [63:0]  r64;
  int t, vi, any_rdy, any_busy, found;

  initial begin
    cmd_valid = 1'b0; cmd_pattern = '0; cmd_gens = '0;
    hpat = 36'b111 << 7;
    vpat = (36'd1 << 2) | (36'd1 << 8) | (36'd1 << 14);
    repeat (3) @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rst_gol_in", gol_in, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_valid, err_short, done}, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // Reset while loading shift index 10.
    eng_reset();
    do_handshake(36'h5_A5A5_A5A5, 3, t);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    ref_fd = '0;
    @(negedge clock);
    check("midrst_gol_in", gol_in, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    repeat (20) @(negedge clock);
    check("midrst_no_done", dut_ev.size(), 0);

    run_cmd(36'h0_0000_0001, 0, "gens0");

    run_cmd(hpat, 3, "blinker");
    vi = 0;
    foreach (dut_ev[j]) if (dut_ev[j].kind == 1) begin
      check("blinker_shape", dut_ev[j].data, (vi % 2 == 0) ? vpat : hpat);
      vi++;
    end
    check("blinker_nframes", vi, 3);

    next_plan = '{40, 40};
    run_cmd(36'h0_0000_1C00, 2, "long40");
    next_plan = '{20, N};
    run_cmd(36'h0_0001_C000, 1, "short20");
    check("short20_first_kind", (dut_ev.size() > 0) ? dut_ev[0].kind : 0, 2);

    for (int r = 0; r < 6; r++) begin
      r64 = {$urandom(), $urandom()}; p = r64[N-1:0];
      for (int k = 0; k < 10; k++) begin
        case ($urandom_range(0, 4))
          0: next_plan.push_back(int'($urandom_range(5, N - 1)));
          1: next_plan.push_back(N + int'($urandom_range(1, 6)));
          default: next_plan.push_back(N);
        endcase
      end
      run_cmd(p, int'($urandom_range(1, 4)), "rand");
    end

    // Command offered while the engine is emitting.
    run_cmd(hpat, 0, "running");
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clock);
      if (gol_out[2:1] == 2'b10) found = 1;
    end
    check("busy_engine_out_seen", found, 1);
    @(posedge clock); #1 cmd_valid = 1'b1;
    any_rdy = 0; any_busy = 0;
    repeat (4) begin
      @(negedge clock); any_rdy |= int'(cmd_ready); any_busy |= int'(busy);
    end
    @(posedge clock); #1 cmd_valid = 1'b0;
    check("busy_engine_ready", any_rdy, 0);
    check("busy_engine_no_load", any_busy, 0);

    // Engine forced back to INPUT during WAIT.
    upd_len = 20;
    eng_reset();
    do_handshake(hpat, 2, t);
    check_load(hpat, "abort");
    repeat (5) @(posedge clock);
    @(negedge clock); eng_rst_req = 1'b1;
    wait_done("abort");
    check("abort_nevents", dut_ev.size(), 2);
    check("abort_kind0", (dut_ev.size() > 0) ? dut_ev[0].kind : 0, 2);
    check("abort_idx0", (dut_ev.size() > 0) ? dut_ev[0].idx : -1, 0);
    check("abort_kind1", (dut_ev.size() > 1) ? dut_ev[1].kind : 0, 3);
    upd_len = 0;
    repeat (3) @(negedge clock);
    check("abort_ready_after", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
